// File: rtl/vga_scanout_pkg.sv
// Shared constants for the 160x120 framebuffer scanout.
// The timing defaults give 640x480@60 from a 50 MHz clock.
package vga_scanout_pkg;

    localparam int CNT_W       = 10;

    localparam int H_VISIBLE_D = 640;
    localparam int H_FRONT_D   = 16;
    localparam int H_SYNC_D    = 96;
    localparam int H_BACK_D    = 48;
    localparam int V_VISIBLE_D = 480;
    localparam int V_FRONT_D   = 10;
    localparam int V_SYNC_D    = 2;
    localparam int V_BACK_D    = 33;

    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 525;
    localparam int HS_START    = 656;
    localparam int HS_END      = 752;
    localparam int VS_START    = 490;
    localparam int VS_END      = 492;

    localparam int FB_WIDTH    = 160;
    localparam int SCALE_SHIFT = 2;
    localparam int FB_ADDR_W   = 15;
    localparam int CLR_W       = 3;
    localparam int DAC_W       = 10;

    localparam int CLR_R       = 2;
    localparam int CLR_G       = 1;
    localparam int CLR_B       = 0;

    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
    } sync_t;

    // row*160 + col without a multiplier: 160 = 128 + 32
    function automatic logic [FB_ADDR_W-1:0] fb_index(
        input logic [CNT_W-1:0] hc,
        input logic [CNT_W-1:0] vc
    );
        logic [FB_ADDR_W-1:0] r;
        logic [FB_ADDR_W-1:0] c;
        r = FB_ADDR_W'(vc >> SCALE_SHIFT);
        c = FB_ADDR_W'(hc >> SCALE_SHIFT);
        return (r << 7) + (r << 5) + c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-phase divider, line/frame counters and stage-0 decode.
// Counters advance only on the pix_en half of the 25 MHz phase.
module vga_timing_gen
    import vga_scanout_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_D,
    parameter int H_FRONT   = H_FRONT_D,
    parameter int H_SYNC    = H_SYNC_D,
    parameter int H_BACK    = H_BACK_D,
    parameter int V_VISIBLE = V_VISIBLE_D,
    parameter int V_FRONT   = V_FRONT_D,
    parameter int V_SYNC    = V_SYNC_D,
    parameter int V_BACK    = V_BACK_D
) (
    input  logic             i_clock,
    input  logic             i_resetn,
    output logic             o_phase,
    output logic             o_pix_en,
    output logic [CNT_W-1:0] o_hc,
    output logic [CNT_W-1:0] o_vc,
    output logic             o_visible0,
    output logic             o_hs0,
    output logic             o_vs0
);

    localparam logic [CNT_W-1:0] H_LAST =
        CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_LAST =
        CNT_W'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_FIN = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_FIN = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic             r_phase;
    logic [CNT_W-1:0] r_hc;
    logic [CNT_W-1:0] r_vc;

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_phase <= 1'b0;
            r_hc    <= '0;
            r_vc    <= '0;
        end else begin
            r_phase <= ~r_phase;
            if (r_phase) begin
                if (r_hc == H_LAST) begin
                    r_hc <= '0;
                    r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
                end else begin
                    r_hc <= r_hc + 1'b1;
                end
            end
        end
    end

    assign o_phase    = r_phase;
    assign o_pix_en   = r_phase;
    assign o_hc       = r_hc;
    assign o_vc       = r_vc;
    assign o_visible0 = (r_hc < H_VIS) && (r_vc < V_VIS);
    assign o_hs0      = !((r_hc >= HS_BEG) && (r_hc < HS_FIN));
    assign o_vs0      = !((r_vc >= VS_BEG) && (r_vc < VS_FIN));

endmodule

// File: rtl/vga_scanout.sv
// Framebuffer read side: address stage, colour stage and DAC pins.
// Syncs and blank ride the same two-pixel pipeline as the colour.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_D,
    parameter int H_FRONT   = H_FRONT_D,
    parameter int H_SYNC    = H_SYNC_D,
    parameter int H_BACK    = H_BACK_D,
    parameter int V_VISIBLE = V_VISIBLE_D,
    parameter int V_FRONT   = V_FRONT_D,
    parameter int V_SYNC    = V_SYNC_D,
    parameter int V_BACK    = V_BACK_D
) (
    input  logic                 clock,
    input  logic                 resetn,
    output logic [FB_ADDR_W-1:0] fb_addr,
    input  logic [CLR_W-1:0]     fb_data,
    output logic                 frame_start,
    output logic                 VGA_CLK,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 VGA_BLANK,
    output logic                 VGA_SYNC,
    output logic [DAC_W-1:0]     VGA_R,
    output logic [DAC_W-1:0]     VGA_G,
    output logic [DAC_W-1:0]     VGA_B
);

    localparam logic [CNT_W-1:0] H_LAST =
        CNT_W'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);

    logic             w_phase;
    logic             w_pix_en;
    logic [CNT_W-1:0] w_hc;
    logic [CNT_W-1:0] w_vc;
    logic             w_visible0;
    logic             w_hs0;
    logic             w_vs0;

    logic [FB_ADDR_W-1:0] r_fb_addr;
    sync_t                r_s1;
    logic                 r_blank;
    logic                 r_hs;
    logic                 r_vs;
    logic [DAC_W-1:0]     r_r;
    logic [DAC_W-1:0]     r_g;
    logic [DAC_W-1:0]     r_b;
    logic                 r_frame_start;

    vga_timing_gen #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .i_clock    (clock),
        .i_resetn   (resetn),
        .o_phase    (w_phase),
        .o_pix_en   (w_pix_en),
        .o_hc       (w_hc),
        .o_vc       (w_vc),
        .o_visible0 (w_visible0),
        .o_hs0      (w_hs0),
        .o_vs0      (w_vs0)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_fb_addr     <= '0;
            r_s1          <= '{vis: 1'b0, hs: 1'b1, vs: 1'b1};
            r_blank       <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            // counters are about to step from the last visible line's end
            r_frame_start <= w_pix_en && (w_hc == H_LAST)
                             && (w_vc == V_VIS_LAST);
            if (w_pix_en) begin
                r_fb_addr <= w_visible0 ? fb_index(w_hc, w_vc) : '0;
                r_s1      <= '{vis: w_visible0, hs: w_hs0, vs: w_vs0};
                r_blank   <= r_s1.vis;
                r_hs      <= r_s1.hs;
                r_vs      <= r_s1.vs;
                r_r       <= r_s1.vis ? {DAC_W{fb_data[CLR_R]}} : '0;
                r_g       <= r_s1.vis ? {DAC_W{fb_data[CLR_G]}} : '0;
                r_b       <= r_s1.vis ? {DAC_W{fb_data[CLR_B]}} : '0;
            end
        end
    end

    assign fb_addr     = r_fb_addr;
    assign frame_start = r_frame_start;
    assign VGA_CLK     = w_phase;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK   = r_blank;
    assign VGA_SYNC    = 1'b0;
    assign VGA_R       = r_r;
    assign VGA_G       = r_g;
    assign VGA_B       = r_b;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: reference model driven by elapsed clock count.
// Vertical timing is shortened so whole frames fit a short run.
module tb_vga_scanout;

    localparam int HV  = 640;
    localparam int HF  = 16;
    localparam int HSW = 96;
    localparam int HB  = 48;
    localparam int VV  = 10;
    localparam int VF  = 1;
    localparam int VSW = 2;
    localparam int VB  = 1;
    localparam int HT  = HV + HF + HSW + HB;
    localparam int VT  = VV + VF + VSW + VB;
    localparam int FCLK = 2 * HT * VT;
    localparam int W0  = 8;

    typedef struct packed {
        logic [14:0] addr;
        logic        fs;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        sync;
        logic [9:0]  r;
        logic [9:0]  g;
        logic [9:0]  b;
    } exp_t;

    logic        clock;
    logic        resetn;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        frame_start;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
    logic [9:0]  VGA_R, VGA_G, VGA_B;

    logic [2:0]  fb [0:19199];
    int          k;
    int          checks;
    int          errors;
    int          hs_lo, vs_lo, blank_hi, fs_cnt;

    vga_scanout #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .frame_start (frame_start),
        .VGA_CLK     (VGA_CLK),
        .VGA_HS      (VGA_HS),
        .VGA_VS      (VGA_VS),
        .VGA_BLANK   (VGA_BLANK),
        .VGA_SYNC    (VGA_SYNC),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    always @(posedge clock) fb_data <= fb[fb_addr];

    always @(posedge clock or negedge resetn)
        if (!resetn) k <= 0;
        else k <= k + 1;

    function automatic int model_addr(input int h, input int v);
        return (v / 4) * 160 + h / 4;
    endfunction

    function automatic int pix_addr(input int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        if (h < HV && v < VV) return model_addr(h, v);
        return 0;
    endfunction

    function automatic exp_t model(input logic in_rst, input int kk);
        exp_t e;
        int n, p, h, v;
        logic [2:0] c;
        e = '{addr: 15'd0, fs: 1'b0, vclk: 1'b0, hs: 1'b1, vs: 1'b1,
              blank: 1'b0, sync: 1'b0, r: 10'd0, g: 10'd0, b: 10'd0};
        if (in_rst) return e;
        n = kk / 2;
        e.vclk = (kk % 2) == 1;
        if (n >= 1) e.addr = 15'(pix_addr(n - 1));
        if (kk > 0 && kk % 2 == 0 && n % HT == 0 && (n / HT) % VT == VV)
            e.fs = 1'b1;
        if (n >= 2) begin
            p = n - 2;
            h = p % HT;
            v = (p / HT) % VT;
            e.blank = (h < HV) && (v < VV);
            e.hs = !(h >= HV + HF && h < HV + HF + HSW);
            e.vs = !(v >= VV + VF && v < VV + VF + VSW);
            if (e.blank) begin
                c = fb[pix_addr(p)];
                e.r = c[2] ? 10'h3FF : 10'h000;
                e.g = c[1] ? 10'h3FF : 10'h000;
                e.b = c[0] ? 10'h3FF : 10'h000;
            end
        end
        return e;
    endfunction

    always @(negedge clock) begin
        exp_t e, a;
        e = model(!resetn, k);
        a = '{addr: fb_addr, fs: frame_start, vclk: VGA_CLK, hs: VGA_HS,
              vs: VGA_VS, blank: VGA_BLANK, sync: VGA_SYNC,
              r: VGA_R, g: VGA_G, b: VGA_B};
        checks++;
        if (a !== e) begin
            errors++;
            if (errors < 20)
                $display("FAIL cycle_model k=%0d got %h want %h", k, a, e);
        end
    end

    always @(negedge clock)
        if (resetn && k >= W0 && k < W0 + 2 * FCLK) begin
            if (!VGA_HS) hs_lo++;
            if (!VGA_VS) vs_lo++;
            if (VGA_BLANK) blank_hi++;
            if (frame_start) fs_cnt++;
        end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic wait_k(input int target);
        int guard;
        guard = 0;
        while (k < target && guard < target + 1000) begin
            @(negedge clock);
            guard++;
        end
        checks++;
        if (k != target) begin
            errors++;
            $display("FAIL wait_k got %0d want %0d", k, target);
        end
    endtask

    initial begin
        int hold;
        checks = 0;
        errors = 0;
        hs_lo = 0; vs_lo = 0; blank_hi = 0; fs_cnt = 0;
        resetn = 1'b0;
        for (int i = 0; i < 19200; i++) fb[i] = 3'($urandom);
        fb[0]   = 3'b111;
        fb[321] = 3'b001;

        chk("model_addr_max", model_addr(639, 479), 19199);
        chk("model_addr_321", model_addr(4, 8), 321);

        repeat (10) @(negedge clock);
        chk("reset_hs", int'(VGA_HS), 1);
        chk("reset_blank", int'(VGA_BLANK), 0);
        #2 resetn = 1'b1;
        #1 chk("vclk_before_edge", int'(VGA_CLK), 0);
        wait_k(1);
        chk("vclk_first_rise", int'(VGA_CLK), 1);
        wait_k(3);
        chk("addr_origin", int'(fb_addr), 0);

        wait_k(2 * (8 * HT + 5));
        chk("addr_4_8", int'(fb_addr), 321);
        wait_k(2 * (8 * HT + 6));
        chk("pix_4_8_r", int'(VGA_R), 0);
        chk("pix_4_8_g", int'(VGA_G), 0);
        chk("pix_4_8_b", int'(VGA_B), 'h3FF);

        wait_k(2 * (9 * HT + 640));
        chk("addr_last_vis", int'(fb_addr), 479);
        wait_k(2 * (9 * HT + 641));
        chk("addr_after_last", int'(fb_addr), 0);
        chk("blank_last_vis", int'(VGA_BLANK), 1);
        wait_k(2 * (9 * HT + 642));
        chk("blank_after_last", int'(VGA_BLANK), 0);

        wait_k(2 * VV * HT - 1);
        chk("fs_before", int'(frame_start), 0);
        wait_k(2 * VV * HT);
        chk("fs_pulse", int'(frame_start), 1);
        wait_k(2 * VV * HT + 1);
        chk("fs_after", int'(frame_start), 0);

        wait_k(W0 + 2 * FCLK + 2);
        chk("hs_low_clocks", hs_lo, 2 * VT * 2 * HSW);
        chk("vs_low_clocks", vs_lo, 2 * 3200);
        chk("blank_high_clocks", blank_hi, 2 * VV * 1280);
        chk("frame_start_count", fs_cnt, 2);

        wait_k(2 * (2 * HT * VT + 5 * HT + 300) + 1);
        @(posedge clock);
        #3 chk("pre_reset_blank", int'(VGA_BLANK), 1);
        resetn = 1'b0;
        #1;
        chk("async_rst_addr", int'(fb_addr), 0);
        chk("async_rst_pins",
            int'({frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK}), 'b00110);
        chk("async_rst_rgb", int'(VGA_R | VGA_G | VGA_B), 0);

        hold = $urandom_range(4, 12);
        repeat (hold) @(negedge clock);
        #2 resetn = 1'b1;
        wait_k(1);
        chk("restart_vclk", int'(VGA_CLK), 1);
        wait_k(3);
        chk("restart_addr0", int'(fb_addr), 0);
        wait_k(10);
        chk("restart_addr_4_0", int'(fb_addr), 1);
        wait_k(2 * (HT + 8));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
